// File: rtl/mem_responder.sv
// Word-addressed RAM plus a small memory-mapped I/O block (output port, free-running
// counter with compare/interrupt) behind a single registered read/write access port.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic [31:0] PortOut,
    output logic        Irq,
    output logic        ErrFlag
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        REG_PORT   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } ioReg_t;

    logic [31:0]      ram [DEPTH_WORDS];
    logic [31:0]      portReg;
    logic [31:0]      countReg;
    logic [31:0]      cmpReg;
    logic             matchReg;
    logic             irqEnReg;
    logic             errReg;

    logic [31:0]      ioOffset;
    logic             aligned;
    logic             inRam;
    logic             inIo;
    logic             accessErr;
    logic             ramWr;
    logic             ioWr;
    logic [IDX_W-1:0] wordIdx;
    ioReg_t           ioSel;
    logic [31:0]      readData;

    // Offset subtraction wraps for addresses below IO_BASE, so one unsigned
    // compare covers the window without overflowing at the top of memory.
    always_comb begin
        ioOffset  = Address - IO_BASE;
        aligned   = (Address[1:0] == 2'b00);
        inRam     = ({1'b0, Address} < RAM_BYTES);
        inIo      = (ioOffset < 32'd16);
        accessErr = !aligned || !(inRam || inIo);
        ramWr     = Wr && !accessErr && inRam;
        ioWr      = Wr && !accessErr && !inRam && inIo;
        wordIdx   = Address[IDX_W+1:2];
        ioSel     = ioReg_t'(ioOffset[3:2]);
    end

    always_comb begin
        readData = '0;
        if (!accessErr) begin
            if (inRam) begin
                readData = ram[wordIdx];
            end else begin
                unique case (ioSel)
                    REG_PORT:   readData = portReg;
                    REG_COUNT:  readData = countReg;
                    REG_CMP:    readData = cmpReg;
                    REG_STATUS: readData = {30'b0, irqEnReg, matchReg};
                    default:    readData = '0;
                endcase
            end
        end
    end

    // RAM deliberately has no reset so its contents survive Reset.
    always_ff @(posedge Clock) begin
        if (ramWr) begin
            ram[wordIdx] <= DataIn;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            DataOut  <= '0;
            portReg  <= '0;
            countReg <= '0;
            cmpReg   <= '0;
            matchReg <= 1'b0;
            irqEnReg <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            DataOut <= readData;

            if (ioWr && ioSel == REG_PORT) begin
                portReg <= DataIn;
            end

            if (ioWr && ioSel == REG_COUNT) begin
                countReg <= DataIn;
            end else begin
                countReg <= countReg + 32'd1;
            end

            if (ioWr && ioSel == REG_CMP) begin
                cmpReg <= DataIn;
            end

            // A compare hit takes priority over a same-cycle clear from STATUS.
            if (countReg == cmpReg) begin
                matchReg <= 1'b1;
            end else if (ioWr && ioSel == REG_STATUS && DataIn[0]) begin
                matchReg <= 1'b0;
            end

            if (ioWr && ioSel == REG_STATUS) begin
                irqEnReg <= DataIn[1];
            end

            if (accessErr) begin
                errReg <= 1'b1;
            end
        end
    end

    assign PortOut = portReg;
    assign Irq     = matchReg & irqEnReg;
    assign ErrFlag = errReg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: RAM, I/O registers, errors, reset.
module tb_mem_responder;

    localparam logic [31:0] IO_PORT   = 32'hFFFF_FF00;
    localparam logic [31:0] IO_COUNT  = 32'hFFFF_FF04;
    localparam logic [31:0] IO_CMP    = 32'hFFFF_FF08;
    localparam logic [31:0] IO_STATUS = 32'hFFFF_FF0C;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Address = '0;
    logic        Wr = 1'b0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic [31:0] PortOut;
    logic        Irq;
    logic        ErrFlag;

    int compared = 0;
    int mismatched = 0;

    mem_responder #(
        .DEPTH_WORDS(64),
        .IO_BASE(32'hFFFF_FF00)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Address(Address),
        .Wr(Wr),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .PortOut(PortOut),
        .Irq(Irq),
        .ErrFlag(ErrFlag)
    );

    always #5 Clock = ~Clock;

    // One access cycle; outputs are stable 1 time unit after the edge.
    task automatic step(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        Address = addr;
        Wr      = wr;
        DataIn  = data;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(32'h10, 1'b0, '0);
        step(32'h10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL reset_dataout: got %h expected %h", DataOut, 32'h0); end
        compared++;
        if (PortOut !== 32'h0) begin mismatched++; $display("FAIL reset_portout: got %h expected %h", PortOut, 32'h0); end
        compared++;
        if (Irq !== 1'b0 || ErrFlag !== 1'b0) begin mismatched++; $display("FAIL reset_irq_err: got %b%b expected 00", Irq, ErrFlag); end
        Reset = 1'b0;
        step(IO_COUNT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL count_after_reset0: got %h expected %h", DataOut, 32'h0); end
        step(IO_COUNT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h1) begin mismatched++; $display("FAIL count_after_reset1: got %h expected %h", DataOut, 32'h1); end
        compared++;
        if (Irq !== 1'b0) begin mismatched++; $display("FAIL irq_after_reset: got %b expected 0", Irq); end
    endtask

    task automatic test_ram();
        step(32'h10, 1'b1, 32'h1234_5678);
        step(32'h10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h1234_5678) begin mismatched++; $display("FAIL ram_readback: got %h expected %h", DataOut, 32'h1234_5678); end
        step(32'h20, 1'b1, 32'h5);
        step(32'h20, 1'b1, 32'hA);
        compared++;
        if (DataOut !== 32'h5) begin mismatched++; $display("FAIL ram_read_first: got %h expected %h", DataOut, 32'h5); end
        step(32'h20, 1'b0, '0);
        compared++;
        if (DataOut !== 32'hA) begin mismatched++; $display("FAIL ram_after_write: got %h expected %h", DataOut, 32'hA); end
        step(32'h0, 1'b1, 32'h0BAD_F00D);
        step(32'hFC, 1'b1, 32'hA5A5_A5A5);
        step(32'h0, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL ram_word0: got %h expected %h", DataOut, 32'h0BAD_F00D); end
        step(32'hFC, 1'b0, '0);
        compared++;
        if (DataOut !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL ram_last_word: got %h expected %h", DataOut, 32'hA5A5_A5A5); end
        compared++;
        if (ErrFlag !== 1'b0) begin mismatched++; $display("FAIL ram_no_error: got %b expected 0", ErrFlag); end
    endtask

    task automatic test_count_wrap();
        step(IO_STATUS, 1'b1, 32'h3);
        compared++;
        if (Irq !== 1'b0) begin mismatched++; $display("FAIL status_clear_irq: got %b expected 0", Irq); end
        step(IO_CMP, 1'b1, 32'h0);
        step(IO_COUNT, 1'b1, 32'hFFFF_FFFE);
        step(IO_COUNT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL count_loaded: got %h expected %h", DataOut, 32'hFFFF_FFFE); end
        step(IO_COUNT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL count_max: got %h expected %h", DataOut, 32'hFFFF_FFFF); end
        compared++;
        if (Irq !== 1'b0) begin mismatched++; $display("FAIL irq_before_match: got %b expected 0", Irq); end
        step(IO_COUNT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL count_wrap: got %h expected %h", DataOut, 32'h0); end
        compared++;
        if (Irq !== 1'b1) begin mismatched++; $display("FAIL irq_on_match: got %b expected 1", Irq); end
        step(IO_STATUS, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h3) begin mismatched++; $display("FAIL status_match: got %h expected %h", DataOut, 32'h3); end
    endtask

    task automatic test_set_wins();
        step(IO_COUNT, 1'b1, 32'd10);
        step(IO_CMP, 1'b1, 32'd12);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL cmp_read_first: got %h expected %h", DataOut, 32'h0); end
        step(32'h10, 1'b0, '0);
        step(IO_STATUS, 1'b1, 32'h3);
        compared++;
        if (Irq !== 1'b1) begin mismatched++; $display("FAIL set_wins_irq: got %b expected 1", Irq); end
        step(IO_STATUS, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h3) begin mismatched++; $display("FAIL set_wins_status: got %h expected %h", DataOut, 32'h3); end
        step(IO_STATUS, 1'b1, 32'h1);
        step(IO_STATUS, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL status_cleared: got %h expected %h", DataOut, 32'h0); end
        step(IO_STATUS, 1'b1, 32'h2);
        step(IO_STATUS, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h2 || Irq !== 1'b0) begin mismatched++; $display("FAIL irqen_only: got %h/%b expected 00000002/0", DataOut, Irq); end
    endtask

    task automatic test_port();
        step(IO_PORT, 1'b1, 32'hCAFE);
        compared++;
        if (PortOut !== 32'hCAFE) begin mismatched++; $display("FAIL port_out: got %h expected %h", PortOut, 32'hCAFE); end
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL port_read_first: got %h expected %h", DataOut, 32'h0); end
        step(IO_PORT, 1'b0, '0);
        compared++;
        if (DataOut !== 32'hCAFE) begin mismatched++; $display("FAIL port_read: got %h expected %h", DataOut, 32'hCAFE); end
    endtask

    task automatic test_errors();
        step(32'h10, 1'b0, '0);
        step(32'h13, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL misaligned_data: got %h expected %h", DataOut, 32'h0); end
        compared++;
        if (ErrFlag !== 1'b1) begin mismatched++; $display("FAIL misaligned_err: got %b expected 1", ErrFlag); end
        step(32'h400, 1'b1, 32'hDEAD_BEEF);
        step(32'h12, 1'b1, 32'h55);
        step(32'hFFFF_FF01, 1'b1, 32'h1234);
        compared++;
        if (PortOut !== 32'hCAFE) begin mismatched++; $display("FAIL port_misaligned_ignored: got %h expected %h", PortOut, 32'hCAFE); end
        step(32'hFC, 1'b0, '0);
        step(32'h100, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL ram_end_unmapped: got %h expected %h", DataOut, 32'h0); end
        step(32'hFC, 1'b0, '0);
        step(32'hFFFF_FF10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL io_end_unmapped: got %h expected %h", DataOut, 32'h0); end
        step(32'h0, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL unmapped_no_alias: got %h expected %h", DataOut, 32'h0BAD_F00D); end
        step(32'h10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h1234_5678) begin mismatched++; $display("FAIL misaligned_no_write: got %h expected %h", DataOut, 32'h1234_5678); end
        compared++;
        if (ErrFlag !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b expected 1", ErrFlag); end
    endtask

    task automatic test_reset_mid();
        step(32'h10, 1'b0, '0);
        Reset = 1'b1;
        step(32'h10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0) begin mismatched++; $display("FAIL reset_discard_read: got %h expected %h", DataOut, 32'h0); end
        compared++;
        if (PortOut !== 32'h0 || ErrFlag !== 1'b0) begin mismatched++; $display("FAIL reset_port_err: got %h/%b expected 00000000/0", PortOut, ErrFlag); end
        Reset = 1'b0;
        step(32'h10, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h1234_5678) begin mismatched++; $display("FAIL ram_survives_reset: got %h expected %h", DataOut, 32'h1234_5678); end
        step(32'h0, 1'b0, '0);
        compared++;
        if (DataOut !== 32'h0BAD_F00D) begin mismatched++; $display("FAIL ram0_survives_reset: got %h expected %h", DataOut, 32'h0BAD_F00D); end
        compared++;
        if (Irq !== 1'b0) begin mismatched++; $display("FAIL irq_after_mid_reset: got %b expected 0", Irq); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_count_wrap();
        test_set_wins();
        test_port();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit RAM words, mapped from byte address 0 to 4*DEPTH_WORDS-1.
REQ-002 The block SHALL have parameter IO_BASE, default 32'hFFFF_FF00, giving the base byte address of the 16-byte I/O window.
REQ-003 The block SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port Address, input, 32 bits, the byte address from the CPU.
REQ-006 The block SHALL have port Wr, input, 1 bit; 1 = write, 0 = read.
REQ-007 The block SHALL have port DataIn, input, 32 bits, the write data.
REQ-008 The block SHALL have port DataOut, output, 32 bits, the registered read data.
REQ-009 The block SHALL have port PortOut, output, 32 bits, the memory-mapped output port value.
REQ-010 The block SHALL have port Irq, output, 1 bit, the timer interrupt request.
REQ-011 The block SHALL have port ErrFlag, output, 1 bit, the sticky access-error indicator.

Function
REQ-012 DataOut SHALL be registered, presenting data for the Address sampled at edge N after edge N (one-edge latency), whether Wr is 0 or 1.
REQ-013 Reads SHALL be read-first: on a write cycle, DataOut SHALL return the contents before the write.
REQ-014 A write to a RAM address with Wr=1 SHALL update word Address[..:2] at that edge.
REQ-015 The I/O map SHALL be: IO_BASE+0 PORT (R/W); +4 COUNT (R/W); +8 CMP (R/W); +C STATUS (bit0 MATCH, bit1 IRQEN, others read 0).
REQ-016 COUNT SHALL increment by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-017 A write to COUNT SHALL load DataIn and suppress that cycle's increment.
REQ-018 MATCH SHALL be set on the edge after the cycle in which COUNT==CMP.
REQ-019 Writing STATUS SHALL clear MATCH where DataIn[0]=1 and SHALL load IRQEN from DataIn[1].
REQ-020 When a MATCH set and a MATCH clear occur in the same cycle, the set SHALL win.
REQ-021 Irq SHALL equal MATCH AND IRQEN, combinationally from the registers.
REQ-022 Any access with Address[1:0]!=0 SHALL be an error: write ignored, DataOut=0, ErrFlag set.
REQ-023 Any access outside both the RAM range and the I/O window SHALL be an error: write ignored, DataOut=0, ErrFlag set.
REQ-024 ErrFlag SHALL be sticky until Reset.
REQ-025 Reads of I/O registers SHALL return the value held before that edge's update.

Reset
REQ-026 Reset SHALL clear DataOut, PORT, COUNT, CMP, MATCH, IRQEN and ErrFlag to 0 at the edge, overriding any same-cycle access or increment.
REQ-027 RAM contents SHALL NOT be affected by Reset.
REQ-028 After Reset is released, PortOut SHALL be 0, Irq SHALL be 0, and COUNT SHALL equal 1 one edge later.
REQ-029 Reset asserted mid-sequence SHALL discard any pending read result; the next DataOut SHALL be 0.

Verification
REQ-030 Write 32'h1234_5678 to 0x10, then read 0x10 -> DataOut=32'h1234_5678 one edge after the read.
REQ-031 Write 32'hA to 0x20 while address 0x20 holds 32'h5 -> DataOut=32'h5 after that edge; a subsequent read returns 32'hA.
REQ-032 Write 32'hFFFF_FFFE to COUNT -> reads return 32'hFFFF_FFFF, then 0 (wrap); with CMP=0 and IRQEN=1, MATCH=1 and Irq=1 follow.
REQ-033 Write STATUS 32'h3 in the same cycle as COUNT==CMP -> MATCH stays 1.
REQ-034 Read 0x13 (misaligned), then write to 0x400 (unmapped) -> DataOut=0, ErrFlag=1, RAM unchanged, ErrFlag holds until Reset.
REQ-035 Write PORT=32'hCAFE, then pulse Reset -> PortOut=0 and ErrFlag=0; the RAM word written earlier is still readable.
